// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants and types for the common data bus arbiter
package cdb_arbiter_pkg;
   localparam int DATA_W = 32;
   localparam int ROB_ID_W = 4;
   localparam logic [ROB_ID_W-1:0] RENAMED_ZERO = '0;
   typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer-side handshakes and CDB broadcast of the arbiter
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
   parameter int ROB_ID_W = cdb_arbiter_pkg::ROB_ID_W
);
   logic rdy;
   logic rollback_signal;
   logic alu_has_result;
   logic [ROB_ID_W-1:0] alias_from_alu;
   logic [DATA_W-1:0] result_from_alu;
   logic lsb_has_result;
   logic [ROB_ID_W-1:0] alias_from_lsb;
   logic [DATA_W-1:0] result_from_lsb;
   logic alu_stall;
   logic lsb_stall;
   logic cdb_valid;
   logic [ROB_ID_W-1:0] cdb_alias;
   logic [DATA_W-1:0] cdb_data;
   logic cdb_from_lsb;
   modport master (
      output rdy, rollback_signal, alu_has_result, alias_from_alu, result_from_alu,
             lsb_has_result, alias_from_lsb, result_from_lsb,
      input  alu_stall, lsb_stall, cdb_valid, cdb_alias, cdb_data, cdb_from_lsb
   );
   modport slave (
      input  rdy, rollback_signal, alu_has_result, alias_from_alu, result_from_alu,
             lsb_has_result, alias_from_lsb, result_from_lsb,
      output alu_stall, lsb_stall, cdb_valid, cdb_alias, cdb_data, cdb_from_lsb
   );
endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// result_fifo: circular queue of {alias, data} results awaiting the CDB
module result_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int W = 36,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic flush,
   input  logic [W-1:0] din,
   output logic full,
   output logic empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign head = mem[rd_ptr];
   // storage carries no reset; only pointers and count define validity
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin merge of ALU and LSB results onto one registered CDB
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
   parameter int ROB_ID_W = cdb_arbiter_pkg::ROB_ID_W,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   cdb_arbiter_if.slave b
);
   localparam int EW = ROB_ID_W + DATA_W;
   logic go, flush;
   src_e prio;
   logic alu_push, lsb_push, alu_pop, lsb_pop, alu_empty, lsb_empty;
   logic [EW-1:0] alu_head, lsb_head, win;
   assign go = b.rdy && !b.rollback_signal;
   assign flush = b.rdy && b.rollback_signal;
   assign alu_push = go && b.alu_has_result && !b.alu_stall && b.alias_from_alu != ROB_ID_W'(RENAMED_ZERO);
   assign lsb_push = go && b.lsb_has_result && !b.lsb_stall && b.alias_from_lsb != ROB_ID_W'(RENAMED_ZERO);
   assign alu_pop = go && !alu_empty && (lsb_empty || prio == SRC_ALU);
   assign lsb_pop = go && !lsb_empty && (alu_empty || prio == SRC_LSB);
   assign win = lsb_pop ? lsb_head : alu_head;
   result_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_fifo (
      .clk(clk), .rst(rst), .push(alu_push), .pop(alu_pop), .flush(flush),
      .din({b.alias_from_alu, b.result_from_alu}),
      .full(b.alu_stall), .empty(alu_empty), .head(alu_head)
   );
   result_fifo #(.W(EW), .DEPTH(DEPTH)) u_lsb_fifo (
      .clk(clk), .rst(rst), .push(lsb_push), .pop(lsb_pop), .flush(flush),
      .din({b.alias_from_lsb, b.result_from_lsb}),
      .full(b.lsb_stall), .empty(lsb_empty), .head(lsb_head)
   );
   // prio only toggles on true contention, so a lone source never steals a turn
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         b.cdb_valid <= 1'b0;
         b.cdb_alias <= '0;
         b.cdb_data <= '0;
         b.cdb_from_lsb <= 1'b0;
         prio <= SRC_ALU;
      end else if (b.rdy) begin
         b.cdb_valid <= alu_pop || lsb_pop;
         if (b.rollback_signal) prio <= SRC_ALU;
         else if (!alu_empty && !lsb_empty) prio <= prio == SRC_ALU ? SRC_LSB : SRC_ALU;
         if (alu_pop || lsb_pop) begin
            {b.cdb_alias, b.cdb_data} <= win;
            b.cdb_from_lsb <= lsb_pop;
         end
      end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized check of cdb_arbiter against a queue model
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;
   localparam int DEPTH = 4;
   typedef struct {
      logic [ROB_ID_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;
   ent_t aq[$];
   ent_t lq[$];
   logic m_valid, m_from_lsb, m_prio;
   logic [ROB_ID_W-1:0] m_alias;
   logic [DATA_W-1:0] m_data;
   cdb_arbiter_if b();
   cdb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .b(b));
   always #5 clk = ~clk;
   task automatic model_reset();
      aq.delete();
      lq.delete();
      m_valid = 1'b0;
      m_from_lsb = 1'b0;
      m_prio = 1'b0;
      m_alias = '0;
      m_data = '0;
   endtask
   // one clock edge of the specified behaviour, using the inputs present before the edge
   task automatic model_step();
      bit a_full, l_full, a_ne, l_ne, src;
      ent_t e;
      if (!rst) begin
         model_reset();
         return;
      end
      if (!b.rdy) return;
      if (b.rollback_signal) begin
         aq.delete();
         lq.delete();
         m_valid = 1'b0;
         m_prio = 1'b0;
         return;
      end
      a_full = aq.size() == DEPTH;
      l_full = lq.size() == DEPTH;
      a_ne = aq.size() != 0;
      l_ne = lq.size() != 0;
      src = (a_ne && l_ne) ? m_prio : l_ne;
      if (a_ne && l_ne) m_prio = !m_prio;
      m_valid = a_ne || l_ne;
      if (m_valid) begin
         e = src ? lq.pop_front() : aq.pop_front();
         m_alias = e.a;
         m_data = e.d;
         m_from_lsb = src;
      end
      if (b.alu_has_result && !a_full && b.alias_from_alu != 0) aq.push_back('{b.alias_from_alu, b.result_from_alu});
      if (b.lsb_has_result && !l_full && b.alias_from_lsb != 0) lq.push_back('{b.alias_from_lsb, b.result_from_lsb});
   endtask
   task automatic cyc(input bit av, input int aa, input int ad, input bit lv, input int la, input int ld, input bit r, input bit rb);
      b.alu_has_result = av;
      b.alias_from_alu = ROB_ID_W'(aa);
      b.result_from_alu = DATA_W'(ad);
      b.lsb_has_result = lv;
      b.alias_from_lsb = ROB_ID_W'(la);
      b.result_from_lsb = DATA_W'(ld);
      b.rdy = r;
      b.rollback_signal = rb;
      @(posedge clk);
      model_step();
      #1;
   endtask
   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
   endtask
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   always @(negedge clk)
      if (chk_en) begin
         vectors++;
         if (b.cdb_valid !== m_valid || b.cdb_alias !== m_alias || b.cdb_data !== m_data ||
             b.cdb_from_lsb !== m_from_lsb || b.alu_stall !== (aq.size() == DEPTH) ||
             b.lsb_stall !== (lq.size() == DEPTH)) begin
            miscompares++;
            $display("FAIL cycle_cmp @%0t: dut v=%b a=%0d d=%h lsb=%b stall=%b%b model v=%b a=%0d d=%h lsb=%b stall=%b%b",
                     $time, b.cdb_valid, b.cdb_alias, b.cdb_data, b.cdb_from_lsb, b.alu_stall, b.lsb_stall,
                     m_valid, m_alias, m_data, m_from_lsb, aq.size() == DEPTH, lq.size() == DEPTH);
         end
      end
   initial begin
      int li;
      bit saw_stall;
      int got[$];
      b.rdy = 1'b1;
      b.rollback_signal = 1'b0;
      b.alu_has_result = 1'b0;
      b.alias_from_alu = '0;
      b.result_from_alu = '0;
      b.lsb_has_result = 1'b0;
      b.alias_from_lsb = '0;
      b.result_from_lsb = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", b.cdb_valid, 0);
      chk("reset_alias", b.cdb_alias, 0);
      chk("reset_data", b.cdb_data, 0);
      chk("reset_stalls", {b.alu_stall, b.lsb_stall}, 0);
      #1 rst = 1'b1;
      chk_en = 1'b1;
      // single ALU result: one cycle of latency, then the bus idles
      cyc(1, 5, 'h11, 0, 0, 0, 1, 0);
      chk("lat_push_cycle_valid", b.cdb_valid, 0);
      idle();
      chk("lat_valid", b.cdb_valid, 1);
      chk("lat_alias", b.cdb_alias, 5);
      chk("lat_data", b.cdb_data, 'h11);
      chk("lat_src", b.cdb_from_lsb, 0);
      idle();
      chk("lat_idle_valid", b.cdb_valid, 0);
      chk("lat_idle_alias_hold", b.cdb_alias, 5);
      // contention: ALU wins first with prio 0
      cyc(1, 1, 'hA, 1, 2, 'hB, 1, 0);
      idle();
      chk("rr_first_alias", b.cdb_alias, 1);
      chk("rr_first_src", b.cdb_from_lsb, 0);
      idle();
      chk("rr_second_alias", b.cdb_alias, 2);
      chk("rr_second_data", b.cdb_data, 'hB);
      chk("rr_second_src", b.cdb_from_lsb, 1);
      // three entries queued, then rollback
      cyc(1, 3, 'h30, 1, 4, 'h40, 1, 0);
      cyc(1, 5, 'h50, 1, 6, 'h60, 1, 0);
      chk("rb_pre_alias", b.cdb_alias, 4);
      cyc(1, 8, 'h80, 1, 9, 'h90, 1, 1);
      chk("rb_valid", b.cdb_valid, 0);
      cyc(1, 7, 'h70, 0, 0, 0, 1, 0);
      chk("rb_empty_valid", b.cdb_valid, 0);
      idle();
      chk("rb_new_valid", b.cdb_valid, 1);
      chk("rb_new_alias", b.cdb_alias, 7);
      chk("rb_new_data", b.cdb_data, 'h70);
      // pause with two entries queued
      cyc(1, 3, 'h33, 1, 4, 'h44, 1, 0);
      repeat (3) begin
         cyc(1, 9, 'h99, 1, 10, 'hAA, 0, 1);
         chk("pause_valid", b.cdb_valid, 0);
         chk("pause_alias", b.cdb_alias, 7);
         chk("pause_data", b.cdb_data, 'h70);
      end
      idle();
      chk("drain_first_alias", b.cdb_alias, 3);
      chk("drain_first_src", b.cdb_from_lsb, 0);
      idle();
      chk("drain_second_alias", b.cdb_alias, 4);
      chk("drain_second_src", b.cdb_from_lsb, 1);
      idle();
      chk("drain_done_valid", b.cdb_valid, 0);
      // LSB burst competing with a busy ALU; the LSB holds its result while stalled
      li = 1;
      saw_stall = 1'b0;
      for (int c = 0; c < 60 && got.size() < 10; c++) begin
         bit st;
         st = b.lsb_stall;
         cyc(1, 12, c, li <= 10, li, li * 16, 1, 0);
         if (li <= 10 && !st) li++;
         if (b.lsb_stall) saw_stall = 1'b1;
         if (b.cdb_valid && b.cdb_from_lsb) got.push_back(int'(b.cdb_alias));
      end
      chk("burst_saw_stall", saw_stall, 1);
      chk("burst_count", got.size(), 10);
      for (int i = 0; i < got.size(); i++) chk("burst_order", got[i], i + 1);
      repeat (12) idle();
      // asynchronous reset between edges while the bus is active
      cyc(1, 2, 'h21, 1, 3, 'h31, 1, 0);
      cyc(1, 4, 'h41, 1, 5, 'h51, 1, 0);
      chk("async_pre_valid", b.cdb_valid, 1);
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("async_valid", b.cdb_valid, 0);
      chk("async_alias", b.cdb_alias, 0);
      chk("async_stalls", {b.alu_stall, b.lsb_stall}, 0);
      @(posedge clk);
      model_step();
      #2 rst = 1'b1;
      idle();
      chk("async_discard_valid", b.cdb_valid, 0);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom,
             $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
